// File: rtl/wave_profile_buffer.sv
// Double-buffered per-column wave profile store.
// Game logic fills the back bank; the display reads the front bank by hcount
// with one cycle of latency. Banks trade places only on request, and only at
// the falling edge of vsync, so a frame never shows a half-written profile.
module wave_profile_buffer #(
  parameter int IDX_W        = 10,
  parameter int DATA_W       = 10,
  parameter int DEFAULT_PROF = 384
) (
  input  logic              vclock,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic              vsync,
  input  logic              wr_valid,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_bank,
  output logic [DATA_W-1:0] wave_prof
);

  localparam int                DEPTH    = 1 << IDX_W;
  localparam logic [DATA_W-1:0] DEF_VAL  = DATA_W'(DEFAULT_PROF);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_FILL    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  clr_cnt_q;
  logic              front_bank_q;
  logic              swap_done_q;
  logic              vsync_q;       // registered vsync copy (vsync_d)
  logic [DATA_W-1:0] wave_prof_q;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic              fall;
  logic              clr_we;
  logic              fill_we;
  logic              swap_fire;
  logic              in_range;
  logic              not_scrubbed;
  logic [IDX_W-1:0]  rd_idx;

  // Frame boundary: vsync is active low, so a high-to-low step starts the blank.
  assign fall     = vsync_q & ~vsync;
  assign rd_idx   = hcount[IDX_W-1:0];
  assign in_range = int'({1'b0, hcount}) < DEPTH;
  // While clearing, columns at or beyond the scrub pointer still hold stale
  // data; they read as the default value they are about to receive.
  assign not_scrubbed = clr_we && (rd_idx >= clr_cnt_q);
  assign fill_we      = wr_ready && wr_valid;

  // State register.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR:   if (clr_cnt_q == LAST_IDX) state_d = ST_FILL;
      ST_FILL:    if (swap_req)              state_d = ST_PENDING;
      ST_PENDING: if (fall)                  state_d = ST_FILL;
      default:                               state_d = ST_CLEAR;
    endcase
  end

  // Output decode of the state.
  always_comb begin
    wr_ready  = 1'b0;
    clr_we    = 1'b0;
    swap_fire = 1'b0;
    unique case (state_q)
      ST_CLEAR:   clr_we    = 1'b1;
      ST_FILL:    wr_ready  = 1'b1;
      ST_PENDING: swap_fire = fall;
      default:    clr_we    = 1'b1;
    endcase
  end

  // Control registers and the one-cycle read path.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      clr_cnt_q    <= '0;
      front_bank_q <= 1'b0;
      swap_done_q  <= 1'b0;
      vsync_q      <= 1'b1;
      wave_prof_q  <= DEF_VAL;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here samples pre-edge values regardless of statement order.
      clr_cnt_q   <= clr_we ? clr_cnt_q + 1'b1 : '0;
      vsync_q     <= vsync;
      swap_done_q <= swap_fire;
      if (swap_fire) front_bank_q <= ~front_bank_q;
      if (!in_range || not_scrubbed) wave_prof_q <= DEF_VAL;
      else if (front_bank_q)         wave_prof_q <= bank1[rd_idx];
      else                           wave_prof_q <= bank0[rd_idx];
    end
  end

  // Bank writes: scrub both banks while clearing, else accepted writes go to the back bank.
  always_ff @(posedge vclock) begin
    // NOTE: the banks have no reset; the CLEAR sweep initialises them, which
    // keeps them mappable onto block RAM.
    if (clr_we) begin
      bank0[clr_cnt_q] <= DEF_VAL;
      bank1[clr_cnt_q] <= DEF_VAL;
    end else if (fill_we) begin
      if (front_bank_q) bank0[wr_index] <= wr_data;
      else              bank1[wr_index] <= wr_data;
    end
  end

  assign swap_done  = swap_done_q;
  assign front_bank = front_bank_q;
  assign wave_prof  = wave_prof_q;

endmodule

// File: tb/tb_wave_profile_buffer.sv
// Directed bench for wave_profile_buffer: read results flow through a
// scoreboard queue, control outputs are checked against fixed expectations.
module tb_wave_profile_buffer;

  localparam logic [9:0] DEF = 10'd384;

  logic        vclock = 1'b0;
  logic        reset  = 1'b1;
  logic [10:0] hcount = '0;
  logic        vsync  = 1'b1;
  logic        wr_valid = 1'b0;
  logic [9:0]  wr_index = '0;
  logic [9:0]  wr_data  = '0;
  logic        swap_req = 1'b0;
  logic        wr_ready;
  logic        swap_done;
  logic        front_bank;
  logic [9:0]  wave_prof;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q [$];

  wave_profile_buffer #(
    .IDX_W(10), .DATA_W(10), .DEFAULT_PROF(384)
  ) dut (
    .vclock     (vclock),
    .reset      (reset),
    .hcount     (hcount),
    .vsync      (vsync),
    .wr_valid   (wr_valid),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
    .front_bank (front_bank),
    .wave_prof  (wave_prof)
  );

  always #5 vclock = ~vclock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a column, record its expected profile, compare one edge later.
  task automatic read_step(input logic [10:0] h, input logic [9:0] exp, input string tag);
    logic [9:0] e;
    hcount = h;
    exp_q.push_back(exp);
    @(negedge vclock);
    e = exp_q.pop_front();
    check(tag, wave_prof, e);
  endtask

  task automatic write_step(input logic [9:0] idx, input logic [9:0] data);
    wr_valid = 1'b1;
    wr_index = idx;
    wr_data  = data;
    check("fill_wr_ready", wr_ready, 1);
    @(negedge vclock);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_swap_req();
    swap_req = 1'b1;
    @(negedge vclock);
    swap_req = 1'b0;
  endtask

  initial begin
    // 1: reset, then CLEAR with hcount sweeping
    repeat (3) @(negedge vclock);
    check("rst_front_bank", front_bank, 0);
    check("rst_wave_prof", wave_prof, DEF);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_swap_done", swap_done, 0);
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      check("clear_wr_ready", wr_ready, 0);
      check("clear_swap_done", swap_done, 0);
      if (i % 256 == 0) check("clear_front_bank", front_bank, 0);
      read_step(11'(i), DEF, "clear_prof");
    end
    check("clear_done_wr_ready", wr_ready, 1);
    check("clear_done_front_bank", front_bank, 0);

    // 2: back-bank writes are invisible to the display
    write_step(10'd5, 10'd100);
    write_step(10'd1023, 10'd7);
    read_step(11'd5, DEF, "t2_idx5");
    read_step(11'd1023, DEF, "t2_idx1023");

    // 3: request a swap, then a vsync fall
    pulse_swap_req();
    for (int i = 0; i < 3; i++) begin
      check("t3_pending_wr_ready", wr_ready, 0);
      check("t3_pending_front", front_bank, 0);
      check("t3_pending_swap_done", swap_done, 0);
      @(negedge vclock);
    end
    vsync = 1'b0;
    @(negedge vclock);
    check("t3_front_bank", front_bank, 1);
    check("t3_swap_done_hi", swap_done, 1);
    check("t3_wr_ready_back", wr_ready, 1);
    @(negedge vclock);
    check("t3_swap_done_lo", swap_done, 0);
    vsync = 1'b1;
    read_step(11'd5, 10'd100, "t3_idx5");
    read_step(11'd1023, 10'd7, "t3_idx1023");
    read_step(11'd1100, DEF, "t3_out_of_range");

    // 4: long PENDING with a write held on the bus
    write_step(10'd9, 10'd321);
    pulse_swap_req();
    wr_valid = 1'b1;
    wr_index = 10'd6;
    wr_data  = 10'd55;
    for (int i = 0; i < 2000; i++) begin
      if (i % 400 == 0) begin
        check("t4_wr_ready", wr_ready, 0);
        check("t4_front_bank", front_bank, 1);
        check("t4_swap_done", swap_done, 0);
      end
      @(negedge vclock);
    end
    vsync = 1'b0;
    @(negedge vclock);
    wr_valid = 1'b0;
    check("t4_front_bank_swapped", front_bank, 0);
    check("t4_swap_done", swap_done, 1);
    vsync = 1'b1;
    read_step(11'd9, 10'd321, "t4_idx9_prior_back");
    read_step(11'd6, DEF, "t4_idx6_not_written");
    read_step(11'd5, DEF, "t4_idx5");

    // 5: swap_req and fall in the same cycle defer to the next frame
    repeat (2) @(negedge vclock);
    swap_req = 1'b1;
    vsync    = 1'b0;
    @(negedge vclock);
    swap_req = 1'b0;
    check("t5_no_swap_front", front_bank, 0);
    check("t5_no_swap_done", swap_done, 0);
    check("t5_pending_wr_ready", wr_ready, 0);
    @(negedge vclock);
    check("t5_still_no_swap", swap_done, 0);
    vsync = 1'b1;
    repeat (3) @(negedge vclock);
    check("t5_wait_front", front_bank, 0);
    vsync = 1'b0;
    @(negedge vclock);
    check("t5_front_bank", front_bank, 1);
    check("t5_swap_done_hi", swap_done, 1);
    @(negedge vclock);
    check("t5_swap_done_lo", swap_done, 0);
    vsync = 1'b1;
    read_step(11'd6, DEF, "t5_idx6_dropped_write");
    read_step(11'd5, 10'd100, "t5_idx5");
    read_step(11'd1023, 10'd7, "t5_idx1023");

    // 6: reset while PENDING with front bank 1
    pulse_swap_req();
    check("t6_pending_wr_ready", wr_ready, 0);
    check("t6_pre_front_bank", front_bank, 1);
    check("t6_pre_wave_prof", wave_prof, 10'd7);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_front_bank", front_bank, 0);
    check("t6_rst_wave_prof", wave_prof, DEF);
    check("t6_rst_wr_ready", wr_ready, 0);
    check("t6_rst_swap_done", swap_done, 0);
    @(negedge vclock);
    reset = 1'b0;
    repeat (1023) @(negedge vclock);
    check("t6_clear_last_wr_ready", wr_ready, 0);
    @(negedge vclock);
    check("t6_clear_done_wr_ready", wr_ready, 1);
    check("t6_front_bank", front_bank, 0);
    for (int i = 0; i < 1024; i++) read_step(11'(i), DEF, "t6_col_default");
    read_step(11'd1100, DEF, "t6_out_of_range");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_profile_buffer.md
Name: wave_profile_buffer

Overview:
- Producer side of the per-column waveform profile consumed by the display path.
- Game logic writes one profile value (the screen row of the wave surface) per column into a back bank.
- The display reads the front bank indexed by hcount, with one-cycle latency.
- Banks swap only on request, at the vsync falling edge, so a frame never shows a half-written profile.

Parameters:
- IDX_W, 10, column index width; each bank holds 2**IDX_W entries.
- DATA_W, 10, profile value width (screen row).
- DEFAULT_PROF, 384, value loaded at clear and returned for out-of-range columns.

Ports:
- vclock  in  1  pixel clock (65 MHz); all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- hcount  in  11  current pixel column, 0 at left.
- vsync  in  1  active-low vertical sync from the xvga timing generator.
- wr_valid  in  1  write request from game logic.
- wr_index  in  IDX_W  column to write in the back bank.
- wr_data  in  DATA_W  profile value to write.
- wr_ready  out  1  write accepted when wr_valid & wr_ready on a rising edge.
- swap_req  in  1  single-cycle request to present the back bank at the next frame.
- swap_done  out  1  one-cycle pulse when the swap takes effect.
- front_bank  out  1  bank currently read by the display.
- wave_prof  out  DATA_W  profile value for the column presented one cycle earlier.

Behaviour:
- Reset (asynchronous) values:
  - state=CLEAR, clear counter=0, front_bank=0, wave_prof=DEFAULT_PROF, wr_ready=0, swap_done=0.
  - Registered vsync copy vsync_d=1.
- Storage: two banks of 2**IDX_W x DATA_W. Back bank = ~front_bank.
- Frame edge: fall = vsync_d & ~vsync; vsync_d <= vsync every cycle.
- Read path (every state, including CLEAR):
  - wave_prof <= (hcount < 2**IDX_W) ? front[hcount[IDX_W-1:0]] : DEFAULT_PROF.
  - Latency is exactly 1 cycle.
  - A write to the back bank never affects the read.
- State machine:
  - CLEAR
    - Writes DEFAULT_PROF at the counter address in both banks each cycle; wr_ready=0.
    - After address 2**IDX_W-1 is written, go to FILL. Duration is 2**IDX_W cycles.
    - fall and swap_req are ignored.
  - FILL
    - wr_ready=1. An accepted write stores wr_data at back[wr_index] on that edge.
    - swap_req=1: go to PENDING. A write presented in the same cycle is still accepted.
  - PENDING
    - wr_ready=0; any wr_valid is dropped, with no side effect. Further swap_req is ignored.
    - On an edge with fall=1: front_bank toggles on that edge, swap_done=1 for the following cycle, go to FILL.
- swap_done is otherwise 0. wr_ready is a combinational decode of the state.
- After a swap the new back bank holds the previous front contents. It is not cleared; game logic rewrites the columns it needs.
- Reset asserted mid-operation (any state): all outputs return to reset values immediately. CLEAR restarts from address 0, and any pending swap is lost.
- A fall in the same cycle that swap_req arrives in FILL does not swap; the swap waits for the next frame.

Test Plan:
1. Release reset with hcount sweeping 0..1023:
   - wr_ready stays 0 for exactly 1024 cycles, then 1.
   - wave_prof = 384 throughout.
   - front_bank = 0, swap_done never 1.
2. In FILL, write index 5 = 100 and index 1023 = 7, no swap:
   - hcount = 5 -> wave_prof = 384 one cycle later.
   - hcount = 1023 -> 384.
3. Continue from 2, pulse swap_req, then drive vsync 1->0:
   - wr_ready = 0 until the fall.
   - On the fall edge front_bank = 1; swap_done is high for one cycle.
   - hcount = 5 -> 100, hcount = 1023 -> 7.
   - hcount = 1100 -> 384.
4. Pulse swap_req with no vsync fall for 2000 cycles, with wr_valid held high on index 6 = 55:
   - No write accepted, front_bank unchanged.
   - After the fall and swap, the new front reads back the prior back-bank contents and index 6 is not 55.
5. Issue swap_req and the vsync fall in the same cycle:
   - No swap on that frame.
   - Swap occurs on the next fall, with swap_done pulsing then.
6. Assert reset while in PENDING with front_bank = 1:
   - Immediately front_bank = 0, wave_prof = 384, wr_ready = 0.
   - After 1024 cycles, all columns read 384.
